decode_issue_ctrl: RTL and testbench

//  Sequences the decode stage between fetch and execute. Holds one fetched insn/pc in a decode register

---
 rtl/decode_issue_ctrl_if.sv | 38 +++
 rtl/decode_issue_ctrl.sv | 107 ++++++++++
 tb/tb_decode_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_ctrl_if.sv
// Handshake bundle between fetch, the decode register, decode, execute and writeback.
// The slave modport is the issue controller's view; master is the surrounding pipeline's.
interface decode_issue_ctrl_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned CNTW   = 32
);
    logic              f_valid_i;
    logic [DWIDTH-1:0] f_insn_i;
    logic [AWIDTH-1:0] f_pc_i;
    logic              f_ready_o;
    logic [DWIDTH-1:0] dec_insn_o;
    logic [AWIDTH-1:0] dec_pc_o;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic              x_valid_o;
    logic              x_ready_i;
    logic              wb_valid_i;
    logic [4:0]        wb_rd_i;
    logic              flush_i;
    logic              stall_o;
    logic              sb_busy_o;
    logic [CNTW-1:0]   stall_cnt_o;

    modport slave (
        input  f_valid_i, f_insn_i, f_pc_i, opcode_i, rd_i, rs1_i, rs2_i,
        input  x_ready_i, wb_valid_i, wb_rd_i, flush_i,
        output f_ready_o, dec_insn_o, dec_pc_o, x_valid_o, stall_o, sb_busy_o, stall_cnt_o
    );

    modport master (
        output f_valid_i, f_insn_i, f_pc_i, opcode_i, rd_i, rs1_i, rs2_i,
        output x_ready_i, wb_valid_i, wb_rd_i, flush_i,
        input  f_ready_o, dec_insn_o, dec_pc_o, x_valid_o, stall_o, sb_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: one-entry decode register, scoreboard-based RAW/WAW stall,
// SYSTEM serialization against pending writes, and a saturating stall counter.
module decode_issue_ctrl #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned CNTW   = 32
) (
    input logic               clk,
    input logic               rst,
    decode_issue_ctrl_if.slave bus
);

    localparam logic [6:0]        SystemOpcode = 7'b1110011;
    localparam logic [DWIDTH-1:0] NopInsn      = DWIDTH'(32'h0000_0013);

    typedef enum logic [0:0] {StEmpty = 1'b0, StFull = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] dec_insn_q, dec_insn_d;
    logic [AWIDTH-1:0] dec_pc_q, dec_pc_d;
    logic [NREGS-1:0]  sb_q, sb_d;
    logic [NREGS-1:0]  sb_eff, clr_mask, set_mask;
    logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;

    logic d_valid, hazard, x_valid, issue, stall, f_ready, accept;

    // Writeback in the same cycle is bypassed so a retiring register no longer blocks issue.
    always_comb begin
        clr_mask = '0;
        if (bus.wb_valid_i && (bus.wb_rd_i != 5'd0)) clr_mask[bus.wb_rd_i] = 1'b1;
        sb_eff    = sb_q & ~clr_mask;
        sb_eff[0] = 1'b0;
        hazard = sb_eff[bus.rs1_i] | sb_eff[bus.rs2_i] | sb_eff[bus.rd_i]
               | ((bus.opcode_i == SystemOpcode) && (|sb_eff));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StEmpty;
        else      state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull: begin
                if (bus.flush_i)          state_d = StEmpty;
                else if (issue && !accept) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    // FSM outputs; x_valid deliberately ignores f_valid_i to avoid a fetch->execute comb path.
    always_comb begin
        d_valid = (state_q == StFull);
        x_valid = d_valid && !hazard && !bus.flush_i;
        issue   = x_valid && bus.x_ready_i;
        stall   = d_valid && hazard && !bus.flush_i;
        f_ready = !d_valid || issue;
        accept  = bus.f_valid_i && f_ready && !bus.flush_i;
    end

    // Set wins over clear on the same bit: a WAW insn released by writeback re-marks its rd.
    always_comb begin
        set_mask = '0;
        if (issue && (bus.rd_i != 5'd0)) set_mask[bus.rd_i] = 1'b1;
        sb_d    = (sb_q & ~clr_mask) | set_mask;
        sb_d[0] = 1'b0;

        dec_insn_d = dec_insn_q;
        dec_pc_d   = dec_pc_q;
        if (accept) begin
            dec_insn_d = bus.f_insn_i;
            dec_pc_d   = bus.f_pc_i;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNTW{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_insn_q  <= NopInsn;
            dec_pc_q    <= '0;
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            dec_insn_q  <= dec_insn_d;
            dec_pc_q    <= dec_pc_d;
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.f_ready_o   = f_ready;
    assign bus.x_valid_o   = x_valid;
    assign bus.stall_o     = stall;
    assign bus.dec_insn_o  = dec_insn_q;
    assign bus.dec_pc_o    = dec_pc_q;
    assign bus.sb_busy_o   = |sb_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl; the bench also plays the decode block, deriving
// opcode/rd/rs1/rs2 from dec_insn_o for R, I, load and SYSTEM formats.
module tb_decode_issue_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    decode_issue_ctrl_if #(.DWIDTH(32), .AWIDTH(32), .CNTW(32)) bus ();

    decode_issue_ctrl #(
        .DWIDTH(32),
        .AWIDTH(32),
        .NREGS (32),
        .CNTW  (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode model: zero out fields the format does not use.
    always_comb begin
        bus.opcode_i = bus.dec_insn_o[6:0];
        bus.rd_i     = 5'd0;
        bus.rs1_i    = 5'd0;
        bus.rs2_i    = 5'd0;
        case (bus.dec_insn_o[6:0])
            7'h33: begin
                bus.rd_i  = bus.dec_insn_o[11:7];
                bus.rs1_i = bus.dec_insn_o[19:15];
                bus.rs2_i = bus.dec_insn_o[24:20];
            end
            7'h13, 7'h03: begin
                bus.rd_i  = bus.dec_insn_o[11:7];
                bus.rs1_i = bus.dec_insn_o[19:15];
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic drive_idle();
        bus.f_valid_i  = 1'b0;
        bus.f_insn_i   = 32'd0;
        bus.f_pc_i     = 32'd0;
        bus.x_ready_i  = 1'b1;
        bus.wb_valid_i = 1'b0;
        bus.wb_rd_i    = 5'd0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] insn, input logic [31:0] pc);
        bus.f_valid_i = 1'b1;
        bus.f_insn_i  = insn;
        bus.f_pc_i    = pc;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.dec_insn_o !== 32'h0000_0013) begin n_fail++;
            $display("FAIL rst_dec_insn got %h want 00000013", bus.dec_insn_o); end
        n_cmp++; if (bus.dec_pc_o !== 32'd0) begin n_fail++;
            $display("FAIL rst_dec_pc got %h want 0", bus.dec_pc_o); end
        n_cmp++; if (bus.x_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_xv_stall got %b%b want 00", bus.x_valid_o, bus.stall_o); end
        n_cmp++; if (bus.f_ready_o !== 1'b1 || bus.sb_busy_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_fr_sb got %b%b want 10", bus.f_ready_o, bus.sb_busy_o); end
        n_cmp++; if (bus.stall_cnt_o !== 32'd0) begin n_fail++;
            $display("FAIL rst_cnt got %0d want 0", bus.stall_cnt_o); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); drive_idle(); fetch(addi(5'd1, 5'd0, 12'd1), 32'h100); #1;
        n_cmp++; if (bus.x_valid_o !== 1'b0 || bus.f_ready_o !== 1'b1) begin n_fail++;
            $display("FAIL b2b_empty got xv=%b fr=%b want 0 1", bus.x_valid_o, bus.f_ready_o); end
        @(negedge clk); fetch(addi(5'd2, 5'd0, 12'd2), 32'h104); #1;
        n_cmp++; if (bus.dec_insn_o !== addi(5'd1, 5'd0, 12'd1) || bus.x_valid_o !== 1'b1
                     || bus.f_ready_o !== 1'b1) begin n_fail++;
            $display("FAIL b2b_issue1 got %h xv=%b fr=%b want %h 1 1", bus.dec_insn_o,
                     bus.x_valid_o, bus.f_ready_o, addi(5'd1, 5'd0, 12'd1)); end
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.dec_pc_o !== 32'h104 || bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL b2b_issue2 got pc=%h xv=%b want 104 1", bus.dec_pc_o,
                     bus.x_valid_o); end
        @(negedge clk); bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd1; #1;
        n_cmp++; if (bus.x_valid_o !== 1'b0 || bus.sb_busy_o !== 1'b1
                     || bus.stall_cnt_o !== 32'd0) begin n_fail++;
            $display("FAIL b2b_after got xv=%b sb=%b cnt=%0d want 0 1 0", bus.x_valid_o,
                     bus.sb_busy_o, bus.stall_cnt_o); end
        @(negedge clk); bus.wb_rd_i = 5'd2; #1;
        n_cmp++; if (bus.sb_busy_o !== 1'b1) begin n_fail++;
            $display("FAIL b2b_x2_pending got %b want 1", bus.sb_busy_o); end
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.sb_busy_o !== 1'b0) begin n_fail++;
            $display("FAIL b2b_sb_clear got %b want 0", bus.sb_busy_o); end
    endtask

    task automatic test_raw();
        @(negedge clk); drive_idle(); fetch(add(5'd5, 5'd1, 5'd2), 32'h110);
        @(negedge clk); fetch(add(5'd6, 5'd5, 5'd5), 32'h114); #1;
        n_cmp++; if (bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL raw_issue_x5 got %b want 1", bus.x_valid_o); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_idle(); #1;
            n_cmp++; if (bus.stall_o !== 1'b1 || bus.x_valid_o !== 1'b0) begin n_fail++;
                $display("FAIL raw_stall%0d got st=%b xv=%b want 1 0", i, bus.stall_o,
                         bus.x_valid_o); end
        end
        @(negedge clk); bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd5; #1;
        n_cmp++; if (bus.stall_o !== 1'b0 || bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL raw_bypass got st=%b xv=%b want 0 1", bus.stall_o, bus.x_valid_o); end
        @(negedge clk); bus.wb_rd_i = 5'd6; #1;
        n_cmp++; if (bus.stall_cnt_o !== 32'd2 || bus.x_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL raw_cnt got cnt=%0d xv=%b want 2 0", bus.stall_cnt_o,
                     bus.x_valid_o); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_waw();
        @(negedge clk); drive_idle(); fetch(lw(5'd7, 5'd0), 32'h120);
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL waw_issue_lw got %b want 1", bus.x_valid_o); end
        @(negedge clk); fetch(addi(5'd7, 5'd0, 12'd1), 32'h124);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_idle(); #1;
            n_cmp++; if (bus.stall_o !== 1'b1) begin n_fail++;
                $display("FAIL waw_stall%0d got %b want 1", i, bus.stall_o); end
        end
        @(negedge clk); bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd7; #1;
        n_cmp++; if (bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL waw_release got %b want 1", bus.x_valid_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.sb_busy_o !== 1'b1 || bus.stall_cnt_o !== 32'd4) begin n_fail++;
            $display("FAIL waw_sb7_set got sb=%b cnt=%0d want 1 4", bus.sb_busy_o,
                     bus.stall_cnt_o); end
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.sb_busy_o !== 1'b0) begin n_fail++;
            $display("FAIL waw_sb_clear got %b want 0", bus.sb_busy_o); end
    endtask

    task automatic test_backpressure();
        @(negedge clk); drive_idle(); bus.x_ready_i = 1'b0; fetch(addi(5'd9, 5'd0, 12'd5), 32'h200);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); fetch(addi(5'd10, 5'd0, 12'd6), 32'h204); #1;
            n_cmp++; if (bus.x_valid_o !== 1'b1 || bus.f_ready_o !== 1'b0
                         || bus.dec_insn_o !== addi(5'd9, 5'd0, 12'd5)
                         || bus.dec_pc_o !== 32'h200) begin n_fail++;
                $display("FAIL bp_hold%0d got xv=%b fr=%b insn=%h pc=%h want 1 0 %h 200", i,
                         bus.x_valid_o, bus.f_ready_o, bus.dec_insn_o, bus.dec_pc_o,
                         addi(5'd9, 5'd0, 12'd5)); end
        end
        @(negedge clk); bus.x_ready_i = 1'b1; #1;
        n_cmp++; if (bus.f_ready_o !== 1'b1 || bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL bp_release got fr=%b xv=%b want 1 1", bus.f_ready_o, bus.x_valid_o); end
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.dec_pc_o !== 32'h204 || bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL bp_next got pc=%h xv=%b want 204 1", bus.dec_pc_o, bus.x_valid_o); end
        @(negedge clk); bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd9; #1;
        n_cmp++; if (bus.x_valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd4) begin n_fail++;
            $display("FAIL bp_done got xv=%b cnt=%0d want 0 4", bus.x_valid_o,
                     bus.stall_cnt_o); end
        @(negedge clk); bus.wb_rd_i = 5'd10;
        @(negedge clk); drive_idle();
    endtask

    task automatic test_flush();
        @(negedge clk); drive_idle(); fetch(lw(5'd12, 5'd0), 32'h300);
        @(negedge clk); fetch(addi(5'd13, 5'd12, 12'd1), 32'h304);
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.stall_o !== 1'b1) begin n_fail++;
            $display("FAIL fl_stalled got %b want 1", bus.stall_o); end
        @(negedge clk); bus.flush_i = 1'b1; fetch(addi(5'd14, 5'd0, 12'd0), 32'h308); #1;
        n_cmp++; if (bus.stall_o !== 1'b0 || bus.x_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL fl_cycle got st=%b xv=%b want 0 0", bus.stall_o, bus.x_valid_o); end
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.x_valid_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.f_ready_o !== 1'b1)
            begin n_fail++;
            $display("FAIL fl_empty got xv=%b st=%b fr=%b want 0 0 1", bus.x_valid_o,
                     bus.stall_o, bus.f_ready_o); end
        n_cmp++; if (bus.dec_pc_o !== 32'h304) begin n_fail++;
            $display("FAIL fl_not_captured got pc=%h want 304", bus.dec_pc_o); end
        n_cmp++; if (bus.sb_busy_o !== 1'b1 || bus.stall_cnt_o !== 32'd5) begin n_fail++;
            $display("FAIL fl_sb_kept got sb=%b cnt=%0d want 1 5", bus.sb_busy_o,
                     bus.stall_cnt_o); end
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd12;
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.sb_busy_o !== 1'b0) begin n_fail++;
            $display("FAIL fl_sb_clear got %b want 0", bus.sb_busy_o); end
    endtask

    task automatic test_system();
        @(negedge clk); drive_idle(); fetch(addi(5'd3, 5'd0, 12'd3), 32'h400);
        @(negedge clk); fetch(32'h0000_0073, 32'h404);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_idle(); #1;
            n_cmp++; if (bus.stall_o !== 1'b1 || bus.x_valid_o !== 1'b0) begin n_fail++;
                $display("FAIL sys_stall%0d got st=%b xv=%b want 1 0", i, bus.stall_o,
                         bus.x_valid_o); end
        end
        @(negedge clk); bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd3; #1;
        n_cmp++; if (bus.x_valid_o !== 1'b1) begin n_fail++;
            $display("FAIL sys_issue got %b want 1", bus.x_valid_o); end
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.sb_busy_o !== 1'b0 || bus.stall_cnt_o !== 32'd7) begin n_fail++;
            $display("FAIL sys_after got sb=%b cnt=%0d want 0 7", bus.sb_busy_o,
                     bus.stall_cnt_o); end
        // Re-create the serialized stall, then reset asynchronously in the middle of it.
        @(negedge clk); fetch(addi(5'd3, 5'd0, 12'd3), 32'h410);
        @(negedge clk); fetch(32'h0000_0073, 32'h414);
        @(negedge clk); drive_idle(); #1;
        n_cmp++; if (bus.stall_o !== 1'b1) begin n_fail++;
            $display("FAIL sys_stall_pre_rst got %b want 1", bus.stall_o); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.dec_insn_o !== 32'h0000_0013 || bus.dec_pc_o !== 32'd0) begin n_fail++;
            $display("FAIL sys_rst_dec got %h %h want 00000013 0", bus.dec_insn_o,
                     bus.dec_pc_o); end
        n_cmp++; if (bus.stall_o !== 1'b0 || bus.x_valid_o !== 1'b0 || bus.sb_busy_o !== 1'b0
                     || bus.f_ready_o !== 1'b1) begin n_fail++;
            $display("FAIL sys_rst_ctl got st=%b xv=%b sb=%b fr=%b want 0 0 0 1", bus.stall_o,
                     bus.x_valid_o, bus.sb_busy_o, bus.f_ready_o); end
        n_cmp++; if (bus.stall_cnt_o !== 32'd0) begin n_fail++;
            $display("FAIL sys_rst_cnt got %0d want 0", bus.stall_cnt_o); end
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_back_to_back();
        test_raw();
        test_waw();
        test_backpressure();
        test_flush();
        test_system();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
